// File: rtl/lsq_pkg.sv
// Shared LSU store-queue types, default sizing and wrap-aware pointer age compare.
// Pure definitions: no latency, no backpressure.
package lsq_pkg;

  localparam int SQ_DEPTH  = 8;
  localparam int SQ_ADDR_W = 64;
  localparam int SQ_DATA_W = 64;
  localparam int SQ_IDX_W  = $clog2(SQ_DEPTH);

  typedef logic [SQ_IDX_W-1:0] sq_idx_t;
  typedef logic [SQ_IDX_W:0]   sq_ptr_t;

  // True when pointer a sits strictly before pointer b, both measured from head
  // in a ptr_w-bit wrap space (head <= a, b <= head + 2^(ptr_w-1)).
  function automatic logic ptr_older(input logic [31:0] a,
                                     input logic [31:0] b,
                                     input logic [31:0] head,
                                     input int unsigned ptr_w);
    logic [31:0] mask;
    mask = (32'h1 << ptr_w) - 32'h1;
    return ((a - head) & mask) < ((b - head) & mask);
  endfunction

endpackage

// File: rtl/sq_fwd_sel.sv
// Youngest-older-store picker: scans entries from head upward, last eligible one wins.
// Combinational, zero latency; no backpressure.
module sq_fwd_sel #(
  parameter int DEPTH = 8,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] older,
  input  logic [DEPTH-1:0] match,
  input  logic [IDX_W-1:0] head_idx,
  output logic             sel_vld,
  output logic [IDX_W-1:0] sel_idx
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    sel_vld = 1'b0;
    sel_idx = head_idx;
    cand    = head_idx;
    for (int k = 0; k < DEPTH; k++) begin
      cand = head_idx + IDX_W'(k);
      if (older[cand] && match[cand]) begin
        sel_vld = 1'b1;
        sel_idx = cand;
      end
    end
  end

endmodule

// File: rtl/sq_fwd_param.sv
// Store queue with byte-enable aware store-to-load forwarding and in-order D-cache drain.
// Load queries combinational; pointers/drain registered; drain stalls on dc_st_rdy_i, dispatch into a full queue is dropped.
module sq_fwd_param import lsq_pkg::*; #(
  parameter int    DEPTH  = SQ_DEPTH,
  parameter int    ADDR_W = SQ_ADDR_W,
  parameter int    DATA_W = SQ_DATA_W,
  localparam int   IDX_W  = $clog2(DEPTH),
  localparam int   BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dp_en_i,
  output logic [IDX_W:0]    dp_ptr_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [IDX_W:0]    count_o,
  input  logic              ex_st_vld_i,
  input  logic [IDX_W-1:0]  ex_st_idx_i,
  input  logic [ADDR_W-1:0] ex_st_addr_i,
  input  logic [DATA_W-1:0] ex_st_data_i,
  input  logic [BE_W-1:0]   ex_st_be_i,
  input  logic              rt_st_en_i,
  input  logic              ld_q_vld_i,
  input  logic [IDX_W:0]    ld_q_pos_i,
  input  logic [ADDR_W-1:0] ld_q_addr_i,
  input  logic [BE_W-1:0]   ld_q_be_i,
  output logic              ld_q_rdy_o,
  output logic              ld_fwd_hit_o,
  output logic              ld_fwd_conflict_o,
  output logic [DATA_W-1:0] ld_fwd_data_o,
  output logic              dc_st_vld_o,
  output logic [ADDR_W-1:0] dc_st_addr_o,
  output logic [DATA_W-1:0] dc_st_data_o,
  output logic [BE_W-1:0]   dc_st_be_o,
  input  logic              dc_st_rdy_i,
  input  logic              br_recover_i,
  input  logic [IDX_W:0]    br_tail_i
);

  localparam int          OFF_W = $clog2(BE_W);
  localparam int unsigned PTR_W = IDX_W + 1;

  typedef logic [IDX_W:0]   ptr_t;
  typedef logic [IDX_W-1:0] idx_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [BE_W-1:0]   be;
  } ent_t;

  ptr_t             head, cmt, tail;
  idx_t             head_idx, tail_idx;
  logic [DEPTH-1:0] addr_vld;
  ent_t             ent [DEPTH];
  logic             full, dc_fire;

  assign head_idx = head[IDX_W-1:0];
  assign tail_idx = tail[IDX_W-1:0];
  assign full     = (head[IDX_W] != tail[IDX_W]) && (head_idx == tail_idx);

  assign dp_ptr_o    = tail;
  assign full_o      = full;
  assign empty_o     = (head == tail);
  assign count_o     = tail - head;
  assign dc_st_vld_o = (head != cmt);
  assign dc_fire     = dc_st_vld_o && dc_st_rdy_i;

  assign dc_st_addr_o = ent[head_idx].addr;
  assign dc_st_data_o = ent[head_idx].data;
  assign dc_st_be_o   = ent[head_idx].be;

  // Drain clears addr_vld last so a freed slot never looks resolved to a later load.
  always_ff @(posedge clk) begin
    if (rst) begin
      head     <= '0;
      cmt      <= '0;
      tail     <= '0;
      addr_vld <= '0;
    end else begin
      if (br_recover_i) begin
        tail <= br_tail_i;
      end else if (dp_en_i && !full) begin
        tail               <= tail + ptr_t'(1);
        addr_vld[tail_idx] <= 1'b0;
      end
      if (ex_st_vld_i) addr_vld[ex_st_idx_i] <= 1'b1;
      if (rt_st_en_i)  cmt <= cmt + ptr_t'(1);
      if (dc_fire) begin
        head               <= head + ptr_t'(1);
        addr_vld[head_idx] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ex_st_vld_i) begin
      ent[ex_st_idx_i] <= '{addr: ex_st_addr_i, data: ex_st_data_i, be: ex_st_be_i};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(rt_st_en_i && (cmt == tail)));
      assert (!(br_recover_i && ptr_older(32'(br_tail_i), 32'(cmt), 32'(head), PTR_W)));
    end
  end

  logic [DEPTH-1:0] older, match;
  idx_t             off;

  always_comb begin
    older = '0;
    match = '0;
    off   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off      = idx_t'(i) - head_idx;
      older[i] = ptr_older(32'(head) + 32'(off), 32'(ld_q_pos_i), 32'(head), PTR_W);
      match[i] = addr_vld[i]
               && (ent[i].addr[ADDR_W-1:OFF_W] == ld_q_addr_i[ADDR_W-1:OFF_W])
               && (|(ent[i].be & ld_q_be_i));
    end
  end

  assign ld_q_rdy_o = ~|(older & ~addr_vld);

  logic sel_vld;
  idx_t sel_idx;

  sq_fwd_sel #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_sel (
    .older    (older),
    .match    (match),
    .head_idx (head_idx),
    .sel_vld  (sel_vld),
    .sel_idx  (sel_idx)
  );

  ent_t sel_ent;
  logic covers;

  assign sel_ent           = ent[sel_idx];
  assign covers            = ((sel_ent.be & ld_q_be_i) == ld_q_be_i);
  assign ld_fwd_hit_o      = ld_q_vld_i && sel_vld && covers;
  assign ld_fwd_conflict_o = ld_q_vld_i && sel_vld && !covers;
  assign ld_fwd_data_o     = ld_fwd_hit_o ? sel_ent.data : '0;

  // Byte offset within the data word plays no part in the word-granular match.
  if (OFF_W > 0) begin : g_off
    logic unused_ld_off;
    assign unused_ld_off = ^ld_q_addr_i[OFF_W-1:0];
  end

endmodule

// File: tb/tb_sq_fwd_param.sv
// Directed bench for sq_fwd_param: forwarding queries and drains checked against scoreboards.
module tb_sq_fwd_param;
  import lsq_pkg::*;

  logic        clk, rst;
  logic        dp_en;
  logic [3:0]  dp_ptr, count;
  logic        full, empty;
  logic        ex_st_vld;
  logic [2:0]  ex_st_idx;
  logic [63:0] ex_st_addr, ex_st_data;
  logic [7:0]  ex_st_be;
  logic        rt_st_en;
  logic        ld_q_vld;
  logic [3:0]  ld_q_pos;
  logic [63:0] ld_q_addr;
  logic [7:0]  ld_q_be;
  logic        ld_q_rdy, ld_hit, ld_conf;
  logic [63:0] ld_data;
  logic        dc_vld, dc_rdy;
  logic [63:0] dc_addr, dc_data;
  logic [7:0]  dc_be;
  logic        br_recover;
  logic [3:0]  br_tail;

  sq_fwd_param dut (
    .clk(clk), .rst(rst),
    .dp_en_i(dp_en), .dp_ptr_o(dp_ptr), .full_o(full), .empty_o(empty), .count_o(count),
    .ex_st_vld_i(ex_st_vld), .ex_st_idx_i(ex_st_idx), .ex_st_addr_i(ex_st_addr),
    .ex_st_data_i(ex_st_data), .ex_st_be_i(ex_st_be),
    .rt_st_en_i(rt_st_en),
    .ld_q_vld_i(ld_q_vld), .ld_q_pos_i(ld_q_pos), .ld_q_addr_i(ld_q_addr), .ld_q_be_i(ld_q_be),
    .ld_q_rdy_o(ld_q_rdy), .ld_fwd_hit_o(ld_hit), .ld_fwd_conflict_o(ld_conf), .ld_fwd_data_o(ld_data),
    .dc_st_vld_o(dc_vld), .dc_st_addr_o(dc_addr), .dc_st_data_o(dc_data), .dc_st_be_o(dc_be),
    .dc_st_rdy_i(dc_rdy),
    .br_recover_i(br_recover), .br_tail_i(br_tail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rdy, hit, conf;
    logic [63:0] data;
  } q_exp_t;

  typedef struct {
    logic [63:0] addr, data;
    logic [7:0]  be;
  } st_t;

  q_exp_t qexp[$];
  st_t    sb[$];
  int     checks = 0;
  int     errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic query(input string tag, input logic vld, input logic [3:0] pos,
                       input logic [63:0] addr, input logic [7:0] be,
                       input logic e_rdy, input logic e_hit, input logic e_conf,
                       input logic [63:0] e_data);
    q_exp_t e;
    ld_q_vld  = vld;
    ld_q_pos  = pos;
    ld_q_addr = addr;
    ld_q_be   = be;
    e.rdy = e_rdy; e.hit = e_hit; e.conf = e_conf; e.data = e_data;
    qexp.push_back(e);
    #1;
    e = qexp.pop_front();
    chk({tag, "/rdy"},  64'(ld_q_rdy), 64'(e.rdy));
    chk({tag, "/hit"},  64'(ld_hit),   64'(e.hit));
    chk({tag, "/conf"}, 64'(ld_conf),  64'(e.conf));
    chk({tag, "/data"}, ld_data,       e.data);
  endtask

  task automatic st_exec(input logic [2:0] idx, input logic [63:0] addr,
                         input logic [63:0] data, input logic [7:0] be);
    ex_st_vld  = 1'b1;
    ex_st_idx  = idx;
    ex_st_addr = addr;
    ex_st_data = data;
    ex_st_be   = be;
    tick();
    ex_st_vld  = 1'b0;
  endtask

  task automatic push_st(input logic [63:0] addr, input logic [63:0] data, input logic [7:0] be);
    st_t s;
    s.addr = addr; s.data = data; s.be = be;
    sb.push_back(s);
  endtask

  // Called at a sample point where dc_st_rdy_i is high: the head store leaves this cycle.
  task automatic drain_check(input string tag);
    st_t s;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=drain expected=no_pending_store", tag);
    end else begin
      s = sb.pop_front();
      chk({tag, "/vld"},  64'(dc_vld), 64'(1));
      chk({tag, "/addr"}, dc_addr,     s.addr);
      chk({tag, "/data"}, dc_data,     s.data);
      chk({tag, "/be"},   64'(dc_be),  64'(s.be));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; dp_en = 1'b0; ex_st_vld = 1'b0; ex_st_idx = '0; ex_st_addr = '0;
    ex_st_data = '0; ex_st_be = '0; rt_st_en = 1'b0; ld_q_vld = 1'b0; ld_q_pos = '0;
    ld_q_addr = '0; ld_q_be = '0; dc_rdy = 1'b0; br_recover = 1'b0; br_tail = '0;
    tick(); tick();
    rst = 1'b0;

    chk("rst/full",   64'(full),   64'(0));
    chk("rst/empty",  64'(empty),  64'(1));
    chk("rst/count",  64'(count),  64'(0));
    chk("rst/dp_ptr", 64'(dp_ptr), 64'(0));
    chk("rst/dc_vld", 64'(dc_vld), 64'(0));
    query("rst/q", 1'b0, 4'd0, 64'h0, 8'h00, 1'b1, 1'b0, 1'b0, 64'h0);

    dp_en = 1'b1;
    repeat (8) tick();
    chk("fill/full",   64'(full),   64'(1));
    chk("fill/count",  64'(count),  64'(8));
    chk("fill/dp_ptr", 64'(dp_ptr), 64'(8));
    tick();
    dp_en = 1'b0;
    chk("ovf/dp_ptr", 64'(dp_ptr), 64'(8));
    chk("ovf/count",  64'(count),  64'(8));

    query("unk", 1'b1, 4'd1, 64'h100, 8'h0F, 1'b0, 1'b0, 1'b0, 64'h0);
    ex_st_vld = 1'b1; ex_st_idx = 3'd0; ex_st_addr = 64'h100; ex_st_data = 64'hAA; ex_st_be = 8'hFF;
    #1;
    chk("nobypass/rdy", 64'(ld_q_rdy), 64'(0));
    chk("nobypass/hit", 64'(ld_hit),   64'(0));
    tick();
    ex_st_vld = 1'b0;
    query("known", 1'b1, 4'd1, 64'h100, 8'h0F, 1'b1, 1'b1, 1'b0, 64'hAA);

    st_exec(3'd1, 64'h100, 64'hBB, 8'hFF);
    query("young",  1'b1, 4'd2, 64'h100, 8'h0F, 1'b1, 1'b1, 1'b0, 64'hBB);
    query("sameword", 1'b1, 4'd2, 64'h104, 8'hF0, 1'b1, 1'b1, 1'b0, 64'hBB);
    query("older1", 1'b1, 4'd1, 64'h100, 8'hF0, 1'b1, 1'b1, 1'b0, 64'hAA);
    query("miss",   1'b1, 4'd2, 64'h108, 8'hFF, 1'b1, 1'b0, 1'b0, 64'h0);
    query("pos0",   1'b1, 4'd0, 64'h100, 8'hFF, 1'b1, 1'b0, 1'b0, 64'h0);
    query("gated",  1'b0, 4'd2, 64'h100, 8'h0F, 1'b1, 1'b0, 1'b0, 64'h0);

    st_exec(3'd2, 64'h200, 64'h11223344, 8'h0F);
    query("conf",   1'b1, 4'd3, 64'h200, 8'hFF, 1'b1, 1'b0, 1'b1, 64'h0);
    query("subset", 1'b1, 4'd3, 64'h200, 8'h03, 1'b1, 1'b1, 1'b0, 64'h11223344);
    query("skip2",  1'b1, 4'd3, 64'h100, 8'h0F, 1'b1, 1'b1, 1'b0, 64'hBB);

    st_exec(3'd3, 64'h100, 64'hCC, 8'h0F);
    query("nobe",   1'b1, 4'd4, 64'h100, 8'hF0, 1'b1, 1'b1, 1'b0, 64'hBB);
    query("part3",  1'b1, 4'd4, 64'h100, 8'hFF, 1'b1, 1'b0, 1'b1, 64'h0);
    query("all8",   1'b1, 4'd8, 64'h100, 8'h0F, 1'b0, 1'b1, 1'b0, 64'hCC);
    ld_q_vld = 1'b0;

    chk("pre_rt/dc_vld", 64'(dc_vld), 64'(0));
    rt_st_en = 1'b1;
    tick();
    rt_st_en = 1'b0;
    chk("rt/dc_vld",  64'(dc_vld),  64'(1));
    chk("rt/dc_addr", dc_addr,      64'h100);
    chk("rt/dc_data", dc_data,      64'hAA);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst/empty",  64'(empty),  64'(1));
    chk("midrst/count",  64'(count),  64'(0));
    chk("midrst/dc_vld", 64'(dc_vld), 64'(0));
    chk("midrst/dp_ptr", 64'(dp_ptr), 64'(0));

    dp_en = 1'b1;
    tick(); tick();
    dp_en = 1'b0;
    st_exec(3'd0, 64'h340, 64'h1111, 8'hFF);
    st_exec(3'd1, 64'h348, 64'h2222, 8'h3C);
    rt_st_en = 1'b1;
    push_st(64'h340, 64'h1111, 8'hFF);
    tick();
    push_st(64'h348, 64'h2222, 8'h3C);
    tick();
    rt_st_en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("hold/dc_vld",  64'(dc_vld), 64'(1));
      chk("hold/dc_addr", dc_addr,     64'h340);
      chk("hold/count",   64'(count),  64'(2));
      tick();
    end
    dc_rdy = 1'b1;
    drain_check("drain0");
    tick();
    chk("drain0/count", 64'(count), 64'(1));
    drain_check("drain1");
    tick();
    dc_rdy = 1'b0;
    chk("drained/empty",  64'(empty),  64'(1));
    chk("drained/dc_vld", 64'(dc_vld), 64'(0));
    chk("drained/sb",     64'(sb.size()), 64'(0));

    rst = 1'b1;
    tick();
    rst = 1'b0;
    dp_en = 1'b1;
    repeat (5) tick();
    dp_en = 1'b0;
    st_exec(3'd0, 64'h500, 64'h5555, 8'hFF);
    st_exec(3'd1, 64'h508, 64'h6666, 8'h0F);
    rt_st_en = 1'b1;
    push_st(64'h500, 64'h5555, 8'hFF);
    tick();
    rt_st_en = 1'b0;
    chk("pre_rec/count", 64'(count), 64'(5));

    br_recover = 1'b1; br_tail = 4'd2; dp_en = 1'b1; rt_st_en = 1'b1; dc_rdy = 1'b1;
    push_st(64'h508, 64'h6666, 8'h0F);
    drain_check("rec_drain0");
    tick();
    br_recover = 1'b0; dp_en = 1'b0; rt_st_en = 1'b0;
    chk("rec/dp_ptr", 64'(dp_ptr), 64'(2));
    chk("rec/count",  64'(count),  64'(1));
    chk("rec/full",   64'(full),   64'(0));
    drain_check("rec_drain1");
    tick();
    dc_rdy = 1'b0;
    chk("rec_end/empty",  64'(empty),  64'(1));
    chk("rec_end/dc_vld", 64'(dc_vld), 64'(0));
    chk("rec_end/dp_ptr", 64'(dp_ptr), 64'(2));
    dp_en = 1'b1;
    tick();
    dp_en = 1'b0;
    chk("post_rec/dp_ptr", 64'(dp_ptr), 64'(3));
    chk("post_rec/count",  64'(count),  64'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
